// File: rtl/pcie_link_sequencer.sv
// Bring-up sequencer for the PCIe serial link: PERST# -> PLL lock -> GT reset -> training -> up.
// Define PCIE_LINK_WIDTH_CHECK_EN to reject links that train narrower than MIN_WIDTH.
module pcie_link_sequencer #(
  parameter int NUM_LANES       = 8,
  parameter int PLL_TIMEOUT     = 65535,
  parameter int GT_RESET_CYCLES = 16,
  parameter int TRAIN_TIMEOUT   = 1048575,
  parameter int MAX_RETRIES     = 3,
  parameter int MIN_WIDTH       = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 perst_n,
  input  logic                 pll_lock,
  input  logic                 gt_reset_done,
  input  logic                 link_up,
  input  logic [3:0]           link_width,
  output logic                 gt_reset,
  output logic                 core_reset,
  output logic [NUM_LANES-1:0] lane_enable,
  output logic                 link_ready,
  output logic                 link_fail,
  output logic [1:0]           retry_count,
  output logic [2:0]           state
);

  localparam logic [2:0] S_HOLD     = 3'd0;
  localparam logic [2:0] S_PLL_WAIT = 3'd1;
  localparam logic [2:0] S_GT_RESET = 3'd2;
  localparam logic [2:0] S_GT_WAIT  = 3'd3;
  localparam logic [2:0] S_TRAIN    = 3'd4;
  localparam logic [2:0] S_UP       = 3'd5;
  localparam logic [2:0] S_FAIL     = 3'd6;

  localparam logic [19:0] PLL_LIMIT   = 20'(PLL_TIMEOUT - 1);
  localparam logic [19:0] GT_LIMIT    = 20'(GT_RESET_CYCLES - 1);
  localparam logic [19:0] TRAIN_LIMIT = 20'(TRAIN_TIMEOUT - 1);
  localparam logic [1:0]  MAX_RC      = 2'(MAX_RETRIES);

  logic                 perst_meta_q, perst_sync_q;
  logic [2:0]           state_q, state_d;
  logic [19:0]          cnt_q, cnt_d;
  logic [1:0]           retry_q, retry_d;
  logic                 gt_reset_q, gt_reset_d;
  logic                 core_reset_q, core_reset_d;
  logic [NUM_LANES-1:0] lane_enable_q, lane_enable_d;
  logic                 link_ready_q, link_ready_d;
  logic                 link_fail_q, link_fail_d;
  logic                 do_retry;
  logic                 width_ok;
  logic [NUM_LANES-1:0] up_lanes;

`ifdef PCIE_LINK_WIDTH_CHECK_EN
  always_comb begin
    width_ok = (link_width >= 4'(MIN_WIDTH));
    up_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      up_lanes[i] = (i < int'(link_width));
    end
  end
`else
  logic unused_width;
  assign unused_width = ^{link_width, 4'(MIN_WIDTH)};
  assign width_ok = 1'b1;
  assign up_lanes = '1;
`endif

  // Next state. A synchronized PERST# assertion overrides every other event.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    do_retry = 1'b0;
    case (state_q)
      S_HOLD: begin
        retry_d = '0;
        if (perst_sync_q) state_d = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        if (pll_lock) state_d = S_GT_RESET;
        else if (cnt_q == PLL_LIMIT) do_retry = 1'b1;
      end
      S_GT_RESET: begin
        if (cnt_q == GT_LIMIT) state_d = S_GT_WAIT;
      end
      S_GT_WAIT: begin
        if (!pll_lock) do_retry = 1'b1;
        else if (gt_reset_done) state_d = S_TRAIN;
        else if (cnt_q == PLL_LIMIT) do_retry = 1'b1;
      end
      S_TRAIN: begin
        if (link_up) begin
          if (width_ok) state_d = S_UP;
          else do_retry = 1'b1;
        end else if (!pll_lock) do_retry = 1'b1;
        else if (cnt_q == TRAIN_LIMIT) do_retry = 1'b1;
      end
      S_UP: begin
        if (!link_up || !pll_lock || !width_ok) do_retry = 1'b1;
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_HOLD;
    endcase

    if (do_retry) begin
      if (retry_q == MAX_RC) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 2'd1;
        state_d = S_GT_RESET;
      end
    end

    if (!perst_sync_q) begin
      state_d = S_HOLD;
      retry_d = '0;
    end
  end

  assign cnt_d = (state_d != state_q) ? 20'd0 : cnt_q + 20'd1;

  // Outputs are decoded from the next state so they move together with state.
  always_comb begin
    gt_reset_d    = 1'b1;
    core_reset_d  = 1'b1;
    lane_enable_d = '0;
    link_ready_d  = 1'b0;
    link_fail_d   = 1'b0;
    case (state_d)
      S_GT_WAIT: gt_reset_d = 1'b0;
      S_TRAIN: begin
        gt_reset_d    = 1'b0;
        core_reset_d  = 1'b0;
        lane_enable_d = '1;
      end
      S_UP: begin
        gt_reset_d    = 1'b0;
        core_reset_d  = 1'b0;
        lane_enable_d = up_lanes;
        link_ready_d  = 1'b1;
      end
      S_FAIL: link_fail_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perst_meta_q  <= 1'b0;
      perst_sync_q  <= 1'b0;
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      retry_q       <= '0;
      gt_reset_q    <= 1'b1;
      core_reset_q  <= 1'b1;
      lane_enable_q <= '0;
      link_ready_q  <= 1'b0;
      link_fail_q   <= 1'b0;
    end else begin
      perst_meta_q  <= perst_n;
      perst_sync_q  <= perst_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      gt_reset_q    <= gt_reset_d;
      core_reset_q  <= core_reset_d;
      lane_enable_q <= lane_enable_d;
      link_ready_q  <= link_ready_d;
      link_fail_q   <= link_fail_d;
    end
  end

  assign gt_reset    = gt_reset_q;
  assign core_reset  = core_reset_q;
  assign lane_enable = lane_enable_q;
  assign link_ready  = link_ready_q;
  assign link_fail   = link_fail_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pcie_link_sequencer.sv
// Directed bench for pcie_link_sequencer with short timeouts so every path is reachable quickly.
module tb_pcie_link_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       perst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       gt_reset_done = 1'b0;
  logic       link_up = 1'b0;
  logic [3:0] link_width = 4'd8;
  logic       gt_reset, core_reset, link_ready, link_fail;
  logic [7:0] lane_enable;
  logic [1:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  pcie_link_sequencer #(
    .NUM_LANES(8), .PLL_TIMEOUT(100), .GT_RESET_CYCLES(4),
    .TRAIN_TIMEOUT(200), .MAX_RETRIES(2), .MIN_WIDTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .perst_n(perst_n), .pll_lock(pll_lock),
    .gt_reset_done(gt_reset_done), .link_up(link_up), .link_width(link_width),
    .gt_reset(gt_reset), .core_reset(core_reset), .lane_enable(lane_enable),
    .link_ready(link_ready), .link_fail(link_fail), .retry_count(retry_count),
    .state(state)
  );

  // Clock / reset / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (state === s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (state === s) ok = 1'b1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    perst_n = 1'b0; pll_lock = 1'b0; gt_reset_done = 1'b0;
    link_up = 1'b0; link_width = 4'd8;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic goto_train(output bit ok);
    do_reset();
    perst_n = 1'b1; pll_lock = 1'b1; gt_reset_done = 1'b1;
    wait_state(3'd4, 40, ok);
  endtask

  // Tests
  task automatic test_reset;
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({state, gt_reset, core_reset, lane_enable, link_ready, link_fail, retry_count} !==
        {3'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset_async got st=%0d gt=%b core=%b lanes=%h rdy=%b fail=%b rc=%0d exp st=0 gt=1 core=1 lanes=00 rdy=0 fail=0 rc=0",
               state, gt_reset, core_reset, lane_enable, link_ready, link_fail, retry_count);
    else n_pass++;
    tick(); tick();
    RST = 1'b0;
    tick();
    n_checks++;
    if ({state, gt_reset, core_reset} !== {3'd0, 1'b1, 1'b1})
      $display("FAIL reset_hold got st=%0d gt=%b core=%b exp st=0 gt=1 core=1", state, gt_reset, core_reset);
    else n_pass++;
  endtask

  task automatic test_nominal;
    bit hold_ok;
    do_reset();
    perst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (state !== 3'd0) $display("FAIL nom_sync_delay got st=%0d exp 0", state);
    else n_pass++;
    tick();
    n_checks++;
    if (state !== 3'd1) $display("FAIL nom_pll_wait got st=%0d exp 1", state);
    else n_pass++;
    repeat (7) tick();
    pll_lock = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state !== 3'd2 || gt_reset !== 1'b1) hold_ok = 1'b0;
    end
    n_checks++;
    if (hold_ok !== 1'b1) $display("FAIL nom_gt_reset_4cyc got ok=%b exp 1", hold_ok);
    else n_pass++;
    tick();
    n_checks++;
    if ({state, gt_reset} !== {3'd3, 1'b0})
      $display("FAIL nom_gt_wait got st=%0d gt=%b exp st=3 gt=0", state, gt_reset);
    else n_pass++;
    tick(); tick();
    gt_reset_done = 1'b1;
    tick();
    n_checks++;
    if ({state, gt_reset, core_reset, lane_enable} !== {3'd4, 1'b0, 1'b0, 8'hFF})
      $display("FAIL nom_train got st=%0d gt=%b core=%b lanes=%h exp st=4 gt=0 core=0 lanes=ff",
               state, gt_reset, core_reset, lane_enable);
    else n_pass++;
    repeat (19) tick();
    link_up = 1'b1;
    tick();
    n_checks++;
    if ({state, link_ready, lane_enable, retry_count} !== {3'd5, 1'b1, 8'hFF, 2'd0})
      $display("FAIL nom_up got st=%0d rdy=%b lanes=%h rc=%0d exp st=5 rdy=1 lanes=ff rc=0",
               state, link_ready, lane_enable, retry_count);
    else n_pass++;
  endtask

  task automatic test_link_flap;
    bit ok;
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
    n_checks++;
    if ({state, link_ready, retry_count, core_reset, lane_enable} !== {3'd2, 1'b0, 2'd1, 1'b1, 8'h00})
      $display("FAIL flap_retry got st=%0d rdy=%b rc=%0d core=%b lanes=%h exp st=2 rdy=0 rc=1 core=1 lanes=00",
               state, link_ready, retry_count, core_reset, lane_enable);
    else n_pass++;
    wait_state(3'd5, 20, ok);
    n_checks++;
    if ({ok, retry_count, link_ready} !== {1'b1, 2'd1, 1'b1})
      $display("FAIL flap_recover got reached=%b rc=%0d rdy=%b exp reached=1 rc=1 rdy=1", ok, retry_count, link_ready);
    else n_pass++;
  endtask

  task automatic test_perst_mid_train;
    bit ok;
    link_up = 1'b0;
    wait_state(3'd4, 20, ok);
    n_checks++;
    if ({ok, retry_count} !== {1'b1, 2'd2})
      $display("FAIL perst_train_setup got reached=%b rc=%0d exp reached=1 rc=2", ok, retry_count);
    else n_pass++;
    perst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (state !== 3'd4) $display("FAIL perst_sync_latency got st=%0d exp 4", state);
    else n_pass++;
    tick();
    n_checks++;
    if ({state, core_reset, gt_reset, retry_count} !== {3'd0, 1'b1, 1'b1, 2'd0})
      $display("FAIL perst_to_hold got st=%0d core=%b gt=%b rc=%0d exp st=0 core=1 gt=1 rc=0",
               state, core_reset, gt_reset, retry_count);
    else n_pass++;
  endtask

  task automatic test_pll_timeout_fail;
    int n;
    do_reset();
    perst_n = 1'b1;
    repeat (3) tick();
    n = 0;
    while (state === 3'd1 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 100) $display("FAIL pll_timeout_len got %0d cycles exp 100", n);
    else n_pass++;
    n_checks++;
    if ({state, retry_count} !== {3'd2, 2'd1})
      $display("FAIL pll_timeout_retry got st=%0d rc=%0d exp st=2 rc=1", state, retry_count);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if ({state, gt_reset} !== {3'd3, 1'b0})
      $display("FAIL pll_lost_gt_wait got st=%0d gt=%b exp st=3 gt=0", state, gt_reset);
    else n_pass++;
    tick();
    n_checks++;
    if ({state, retry_count} !== {3'd2, 2'd2})
      $display("FAIL pll_lost_retry2 got st=%0d rc=%0d exp st=2 rc=2", state, retry_count);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if ({state, link_fail, retry_count, gt_reset, core_reset, lane_enable} !== {3'd6, 1'b1, 2'd2, 1'b1, 1'b1, 8'h00})
      $display("FAIL fail_entry got st=%0d fail=%b rc=%0d gt=%b core=%b lanes=%h exp st=6 fail=1 rc=2 gt=1 core=1 lanes=00",
               state, link_fail, retry_count, gt_reset, core_reset, lane_enable);
    else n_pass++;
    pll_lock = 1'b1; gt_reset_done = 1'b1;
    repeat (10) tick();
    n_checks++;
    if ({state, link_fail} !== {3'd6, 1'b1})
      $display("FAIL fail_sticky got st=%0d fail=%b exp st=6 fail=1", state, link_fail);
    else n_pass++;
    perst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({state, link_fail, retry_count} !== {3'd0, 1'b0, 2'd0})
      $display("FAIL fail_to_hold got st=%0d fail=%b rc=%0d exp st=0 fail=0 rc=0", state, link_fail, retry_count);
    else n_pass++;
  endtask

  task automatic test_gt_wait_timeout;
    bit ok;
    int n;
    do_reset();
    perst_n = 1'b1; pll_lock = 1'b1;
    wait_state(3'd3, 30, ok);
    n = 0;
    while (state === 3'd3 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if ({ok, n[7:0], state, retry_count} !== {1'b1, 8'd100, 3'd2, 2'd1})
      $display("FAIL gt_wait_timeout got reached=%b len=%0d st=%0d rc=%0d exp reached=1 len=100 st=2 rc=1",
               ok, n, state, retry_count);
    else n_pass++;
  endtask

  task automatic test_train_timeout;
    bit ok;
    int n;
    goto_train(ok);
    n = 0;
    while (state === 3'd4 && n < 400) begin
      tick();
      n++;
    end
    n_checks++;
    if ({ok, n[8:0], state, retry_count} !== {1'b1, 9'd200, 3'd2, 2'd1})
      $display("FAIL train_timeout got reached=%b len=%0d st=%0d rc=%0d exp reached=1 len=200 st=2 rc=1",
               ok, n, state, retry_count);
    else n_pass++;
    wait_state(3'd4, 20, ok);
    repeat (199) tick();
    link_up = 1'b1;
    tick();
    n_checks++;
    if ({ok, state, retry_count} !== {1'b1, 3'd5, 2'd1})
      $display("FAIL link_up_at_timeout got reached=%b st=%0d rc=%0d exp reached=1 st=5 rc=1", ok, state, retry_count);
    else n_pass++;
  endtask

  task automatic test_perst_with_link_up;
    bit ok;
    goto_train(ok);
    perst_n = 1'b0;
    tick(); tick();
    link_up = 1'b1;
    tick();
    n_checks++;
    if ({ok, state} !== {1'b1, 3'd0})
      $display("FAIL perst_beats_link_up got reached=%b st=%0d exp reached=1 st=0", ok, state);
    else n_pass++;
  endtask

  task automatic test_width;
    bit ok;
    goto_train(ok);
    link_width = 4'd2;
    link_up = 1'b1;
    tick();
`ifdef PCIE_LINK_WIDTH_CHECK_EN
    n_checks++;
    if ({ok, state, retry_count} !== {1'b1, 3'd2, 2'd1})
      $display("FAIL width_narrow_retry got reached=%b st=%0d rc=%0d exp reached=1 st=2 rc=1", ok, state, retry_count);
    else n_pass++;
    link_width = 4'd4;
    wait_state(3'd5, 20, ok);
    n_checks++;
    if ({ok, lane_enable} !== {1'b1, 8'h0F})
      $display("FAIL width_ok_lanes got reached=%b lanes=%h exp reached=1 lanes=0f", ok, lane_enable);
    else n_pass++;
`else
    n_checks++;
    if ({ok, state, lane_enable, retry_count} !== {1'b1, 3'd5, 8'hFF, 2'd0})
      $display("FAIL width_ignored got reached=%b st=%0d lanes=%h rc=%0d exp reached=1 st=5 lanes=ff rc=0",
               ok, state, lane_enable, retry_count);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset;
    bit ok;
    goto_train(ok);
    RST = 1'b1;
    #1;
    n_checks++;
    if ({ok, state, gt_reset, core_reset, lane_enable} !== {1'b1, 3'd0, 1'b1, 1'b1, 8'h00})
      $display("FAIL async_reset got reached=%b st=%0d gt=%b core=%b lanes=%h exp reached=1 st=0 gt=1 core=1 lanes=00",
               ok, state, gt_reset, core_reset, lane_enable);
    else n_pass++;
    tick();
    RST = 1'b0;
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_nominal();
    test_link_flap();
    test_perst_mid_train();
    test_pll_timeout_fail();
    test_gt_wait_timeout();
    test_train_timeout();
    test_perst_with_link_up();
    test_width();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_link_sequencer.md
Name: pcie_link_sequencer

Overview:
- Sequences bring-up of the 8-lane PCIe serial link that passes through the board-level lane wrapper.
- Tracks slot PERST#, GT PLL lock and GT reset completion, then releases the PCIe core and waits for link training.
- Retries on timeout or link loss, up to a bound, then latches a failure.
- Sits between the physical-device reset/clock logic and the PCIe core/GT reset inputs.

Parameters:
NUM_LANES, 8, number of serial lanes gated by lane_enable.
PLL_TIMEOUT, 65535, cycles allowed in PLL_WAIT and GT_WAIT before a retry (1..2^20-1).
GT_RESET_CYCLES, 16, cycles gt_reset is held high in GT_RESET (1..2^20-1).
TRAIN_TIMEOUT, 1048575, cycles allowed in TRAIN before a retry (1..2^20-1).
MAX_RETRIES, 3, retries permitted before FAIL (0..3).
MIN_WIDTH, 8, minimum acceptable negotiated width; used only with the optional feature.

Ports:
CLK  in  1  sole clock.
RST  in  1  asynchronous reset, active-high.
perst_n  in  1  slot PERST#, asynchronous to CLK, active-low.
pll_lock  in  1  GT PLL locked, synchronous to CLK.
gt_reset_done  in  1  GT reset sequence complete.
link_up  in  1  PCIe core data-link-up.
link_width  in  4  negotiated lane count, 1..8.
gt_reset  out  1  GT reset, active-high.
core_reset  out  1  PCIe core reset, active-high.
lane_enable  out  NUM_LANES  per-lane enable to the lane wrapper.
link_ready  out  1  link usable.
link_fail  out  1  sticky bring-up failure.
retry_count  out  2  retries consumed, saturating.
state  out  3  current state encoding.

Behaviour:
- Clock, reset and synchronizer
  - All flops are on CLK with asynchronous active-high RST.
  - On RST: state=HOLD(0), gt_reset=1, core_reset=1, lane_enable=0, link_ready=0, link_fail=0, retry_count=0, cycle counter=0.
  - perst_n passes through a 2-flop synchronizer; both flops reset to 0, so PERST# reads as asserted.
  - Internal counter is 20 bits wide, cleared on every state entry, and reads 0 in the first cycle of a state.
  - All outputs are registered and decoded from the next state, so each output changes in the same cycle as state.
- Global override: if synchronized perst is 0, the next state is HOLD from any state and retry_count clears. This beats every other event.
- States:
  - HOLD(0): gt_reset=1, core_reset=1, lane_enable=0. Synchronized perst=1 goes to PLL_WAIT.
  - PLL_WAIT(1): pll_lock=1 goes to GT_RESET. Otherwise, once the counter reaches PLL_TIMEOUT-1, perform RETRY.
  - GT_RESET(2): gt_reset=1 for exactly GT_RESET_CYCLES cycles, then go to GT_WAIT.
  - GT_WAIT(3): gt_reset=0.
    - pll_lock=0 performs RETRY.
    - Else gt_reset_done=1 goes to TRAIN.
    - Else, at the PLL_TIMEOUT limit, perform RETRY.
  - TRAIN(4): gt_reset=0, core_reset=0, lane_enable all ones.
    - link_up=1 goes to UP. This wins if it coincides with the timeout.
    - pll_lock=0 performs RETRY.
    - At the TRAIN_TIMEOUT limit, perform RETRY.
  - UP(5): link_ready=1, with the same resets and lanes as TRAIN. link_up=0 or pll_lock=0 performs RETRY, and link_ready drops in that cycle.
  - FAIL(6): link_fail=1, gt_reset=1, core_reset=1, lane_enable=0.
    - Left only by PERST# assertion (to HOLD) or RST.
    - link_fail clears on leaving FAIL.
- RETRY:
  - If retry_count==MAX_RETRIES, the next state is FAIL.
  - Otherwise retry_count increments and the next state is GT_RESET, with core_reset=1, lane_enable=0 and link_ready=0.
- retry_count is never cleared by reaching UP. Only HOLD or RST clear it.
- Encoding 7 is unused. If state ever reads 7, it goes to HOLD next cycle.

Optional Feature:
PCIE_LINK_WIDTH_CHECK_EN
- Defined:
  - In TRAIN, link_up=1 with link_width<MIN_WIDTH performs RETRY instead of entering UP.
  - In UP, lane_enable holds only its low link_width bits set.
  - In UP, a change of link_width below MIN_WIDTH performs RETRY.
- Undefined: link_width is ignored, lane_enable is all ones in TRAIN/UP, and MIN_WIDTH is unused.

Test Plan:
- Common bench parameters: PLL_TIMEOUT=100, GT_RESET_CYCLES=4, TRAIN_TIMEOUT=200, MAX_RETRIES=2.
- Nominal bring-up: RST pulse; perst_n=1 at t0; pll_lock=1 at t0+10; gt_reset_done 3 cycles after gt_reset falls; link_up 20 cycles later -> states 0,1,2,3,4,5 in order; gt_reset high exactly 4 cycles in GT_RESET; link_ready=1 and lane_enable=8'hFF in UP; retry_count=0.
- PLL timeout to FAIL: perst_n=1, pll_lock held 0 -> exit after 100 cycles in PLL_WAIT; GT_RESET/GT_WAIT time out twice (retry_count 1,2); third timeout -> state=6, link_fail=1, retry_count=2.
- Link flap: from UP, drop link_up for 1 cycle -> same cycle link_ready=0, state=2, retry_count=1; re-raise link_up -> UP, retry_count stays 1.
- PERST# mid-TRAIN: assert perst_n=0 while state=4 -> state=0 within 3 cycles (sync + 1), core_reset=1, retry_count=0; also verify from FAIL -> HOLD and link_fail=0.
- Simultaneous events: link_up rises in the TRAIN timeout cycle -> UP, no retry; perst_n low in the same cycle as link_up -> HOLD.
- With PCIE_LINK_WIDTH_CHECK_EN, MIN_WIDTH=4: link_width=2 at link_up -> RETRY; link_width=4 -> UP with lane_enable=8'h0F.
